data_mem_uart: RTL and testbench
================================

Name: data_mem_uart

Overview:
- Data-side slave of the CPU core. Decodes the core's data bus (data_Addr, write_data, write_enable) and answers on read_data.
- Holds a word-addressed data/stack RAM and a memory-mapped 8N1 UART transmitter with a small TX FIFO.
- read_data is combinational. The core uses read_data in the same cycle for loads and for ret (PC pop), so no wait states exist.

Parameters:
- ADDR_W, 10, RAM index width; RAM holds 2^ADDR_W 16-bit words.
- FIFO_DEPTH, 4, TX FIFO entries; legal values 2, 4, 8.
- CLKS_PER_BIT, 868, clk cycles per UART bit; minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_Addr  in  16  word address from core.
- write_data  in  16  store data from core.
- write_enable  in  1  store strobe; a write takes effect at the clk edge ending the cycle.
- read_data  out  16  combinational read data for data_Addr.
- uart_tx  out  1  serial output, idle high, registered.

Behaviour:
- Reset: synchronous, active-high; one clk edge with rst=1 is sufficient.

Address map:
- MMIO window = data_Addr[15:2]==14'h2000, i.e. 0x8000-0x8003. MMIO has priority.
- Any other address maps to RAM[data_Addr[ADDR_W-1:0]] (aliasing).
- The stack starts at 0xFFFF after the core's SP reset, so it lands at the top RAM word.
- 0x8000 UART_DATA:
  - write: push write_data[7:0] into the FIFO.
  - read: 0x0000.
- 0x8001 UART_STATUS:
  - read: {8'b0, count[3:0], ovf, busy, empty, full}.
  - write: any value clears ovf.
- 0x8002, 0x8003: read 0x0000, writes ignored.
- MMIO writes never modify RAM.

RAM:
- Asynchronous read, synchronous write.
- Contents are not cleared by rst.
- A read of the address being written in the same cycle returns the old word.

FIFO:
- Circular buffer with rd_ptr, wr_ptr and count (0..FIFO_DEPTH).
- Push when full: data dropped, ovf<=1 (sticky).
- Push and pop in the same cycle:
  - both take effect and count is unchanged.
  - when full, the push is accepted (no ovf).
- Empty = count==0; full = count==FIFO_DEPTH.

TX FSM:
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1.
  - If count>0: pop head into shift reg, bit_cnt<=0, baud_cnt<=0, go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - uart_tx=shift[0], held CLKS_PER_BIT cycles per bit, LSB first.
  - After 8 bits go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy = state!=IDLE.
- Latency: a store to 0x8000 in cycle N (empty FIFO, IDLE) drives uart_tx low from the edge ending cycle N+1.
- Back-to-back frames: period is 10*CLKS_PER_BIT+1 cycles (one IDLE cycle, tx high, between frames).
- baud_cnt wraps at CLKS_PER_BIT-1.

Reset values:
- FIFO pointers and count = 0, ovf = 0.
- state = IDLE, uart_tx = 1.
- shift, baud_cnt and bit_cnt = 0.
- Reset mid-frame aborts the frame:
  - uart_tx is high from the reset edge.
  - Queued bytes are discarded.

Status read timing:
- UART_STATUS reflects registered values in the current cycle.
- A push in cycle N is visible in count from cycle N+1.

Test Plan:
- RAM: store 0xBEEF to 0x0005, then load 0x0005 -> read_data=0xBEEF. Store 0x1234 to 0x0405 (ADDR_W=10) -> load 0x0005 returns 0x1234 (alias).
- Stack alias: store 0xA5A5 to 0xFFFF -> load 0x03FF returns 0xA5A5. Load 0x8000 -> 0x0000; RAM[0x000] unchanged after a store to 0x8000.
- UART frame, CLKS_PER_BIT=4:
  - Store 0x0055 to 0x8000 in cycle N.
  - Required: uart_tx low in cycles N+2..N+5, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles.
  - busy=1 from cycle N+2 through the stop bit.
- FIFO/overflow, CLKS_PER_BIT=4, FIFO_DEPTH=4:
  - 6 consecutive stores to 0x8000 -> first byte popped, status shows count=4, full=1, ovf=1.
  - Store to 0x8001 -> ovf=0.
  - Exactly 5 frames are emitted, with 41-cycle spacing.
- Reset mid-frame: assert rst during the DATA state of a frame with 2 bytes queued -> uart_tx=1 from the reset edge, status reads 0x0002 (empty), no further frames.
- Simultaneous push/pop with full FIFO in IDLE-pop cycle -> count stays 4, ovf=0, pushed byte transmitted last.

Source files
------------

// File: rtl/data_mem_uart.sv
// rtl/data_mem_uart.sv - data-side slave: word RAM plus memory-mapped 8N1 UART TX with FIFO
module data_mem_uart #(
    parameter int ADDR_W       = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_Addr,
    input  logic [15:0] write_data,
    input  logic        write_enable,
    output logic [15:0] read_data,
    output logic        uart_tx
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0]       ram [2**ADDR_W];
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [3:0]        count;
    logic              ovf;

    state_t            state, state_next;
    logic [7:0]        shift, shift_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic              tx_next;

    logic mmio, push_req, push_ok, pop, ovf_clr;
    logic empty, full, busy, baud_end;

    assign mmio     = data_Addr[15:2] == 14'h2000;
    assign push_req = write_enable && mmio && (data_Addr[1:0] == 2'd0);
    assign ovf_clr  = write_enable && mmio && (data_Addr[1:0] == 2'd1);
    assign empty    = count == 4'd0;
    assign full     = count == 4'(FIFO_DEPTH);
    assign busy     = state != IDLE;
    assign pop      = (state == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign baud_end = baud_cnt == BAUD_W'(CLKS_PER_BIT - 1);

    always_comb begin
        read_data = ram[data_Addr[ADDR_W-1:0]];
        if (mmio) begin
            if (data_Addr[1:0] == 2'd1) begin
                read_data = {8'b0, count, ovf, busy, empty, full};
            end else begin
                read_data = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_enable && !mmio) begin
            ram[data_Addr[ADDR_W-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + {3'b0, push_ok} - {3'b0, pop};
            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= 8'd0;
            bit_cnt  <= 3'd0;
            baud_cnt <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_cnt  <= bit_cnt_next;
            baud_cnt <= baud_cnt_next;
            uart_tx  <= tx_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt;
        baud_cnt_next = baud_end ? '0 : baud_cnt + BAUD_W'(1);
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (pop) begin
                    shift_next   = fifo_mem[rd_ptr];
                    bit_cnt_next = 3'd0;
                    state_next   = START;
                end
            end
            START: begin
                if (baud_end) state_next = DATA;
            end
            DATA: begin
                if (baud_end) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (baud_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Output is registered from next-state values so the line changes on the transition edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_data_mem_uart.sv
// tb/tb_data_mem_uart.sv - scoreboard bench for data_mem_uart (RAM, MMIO, UART frames)
module tb_data_mem_uart;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_Addr = 16'h0000;
    logic [15:0] write_data = 16'h0000;
    logic        write_enable = 1'b0;
    logic [15:0] read_data;
    logic        uart_tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int frames = 0;
    logic [7:0] sb[$];
    int start_q[$];

    logic       mon_ok, mon_abort, mon_cur;
    logic [7:0] mon_data;

    data_mem_uart #(
        .ADDR_W(10),
        .FIFO_DEPTH(4),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_Addr(data_Addr),
        .write_data(write_data),
        .write_enable(write_enable),
        .read_data(read_data),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                          output logic [15:0] rv);
        data_Addr    = a;
        write_data   = d;
        write_enable = w;
        #1 rv = read_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        access(a, d, 1'b1, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] want);
        logic [15:0] v;
        access(a, 16'h0000, 1'b0, v);
        chk(tag, {16'h0, v}, {16'h0, want});
    endtask

    task automatic tick();
        write_enable = 1'b0;
        data_Addr    = 16'h0100;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames < n && k < budget) begin
            tick();
            k++;
        end
        chk("frame_count", frames, n);
    endtask

    // Serial receiver: checks each bit is held C cycles and pops the scoreboard per frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                start_q.push_back(cyc);
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_data  = 8'h00;
                mon_cur   = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < C; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst) mon_abort = 1'b1;
                        if (k == 0) mon_cur = uart_tx;
                        else if (uart_tx !== mon_cur) mon_ok = 1'b0;
                        if (k == 0 && b >= 1 && b <= 8) mon_data[3'(b - 1)] = uart_tx;
                        if (k == 0 && b == 9 && uart_tx !== 1'b1) mon_ok = 1'b0;
                    end
                end
                if (!mon_abort) begin
                    chk("frame_shape", {31'h0, mon_ok}, 32'd1);
                    if (sb.size() == 0) chk("frame_unexpected", sb.size(), 32'd1);
                    else chk("frame_byte", {24'h0, mon_data}, {24'h0, sb.pop_front()});
                    frames++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, f0, s0, lows;
        logic [15:0] v;
        logic [7:0] b;

        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_tx", {31'h0, uart_tx}, 32'd1);
        rd_chk("rst_status", 16'h8001, 16'h0002);

        wr(16'h0005, 16'hBEEF);
        rd_chk("ram_rw", 16'h0005, 16'hBEEF);
        wr(16'h0405, 16'h1234);
        rd_chk("ram_alias", 16'h0005, 16'h1234);
        access(16'h0005, 16'h7777, 1'b1, v);
        chk("ram_rdw_old", {16'h0, v}, 32'h1234);
        rd_chk("ram_rdw_new", 16'h0005, 16'h7777);
        wr(16'hFFFF, 16'hA5A5);
        rd_chk("stack_alias", 16'h03FF, 16'hA5A5);
        wr(16'h0000, 16'h1111);
        wr(16'h0002, 16'h2222);
        wr(16'h8002, 16'hFFFF);
        rd_chk("mmio_rsvd2_rd", 16'h8002, 16'h0000);
        rd_chk("mmio_rsvd3_rd", 16'h8003, 16'h0000);
        rd_chk("ram2_kept", 16'h0002, 16'h2222);
        rd_chk("mmio_data_rd", 16'h8000, 16'h0000);

        n = cyc;
        sb.push_back(8'h55);
        wr(16'h8000, 16'h0055);
        rd_chk("status_n1", 16'h8001, 16'h0010);
        rd_chk("status_n2", 16'h8001, 16'h0006);
        rd_chk("ram0_kept", 16'h0000, 16'h1111);
        wait_frames(1, 200);
        chk("tx_latency", start_q[0], n + 2);

        repeat (3) tick();
        f0 = frames;
        s0 = start_q.size();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 5) sb.push_back(b);
            wr(16'h8000, {8'h00, b});
        end
        rd_chk("status_ovf", 16'h8001, 16'h004D);
        wr(16'h8001, 16'h00FF);
        rd_chk("status_ovf_clr", 16'h8001, 16'h0045);
        wait_frames(f0 + 5, 400);
        for (int i = 1; i < 5; i++) begin
            chk("frame_spacing", start_q[s0 + i] - start_q[s0 + i - 1], 32'd41);
        end

        repeat (3) tick();
        n = cyc;
        f0 = frames;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            sb.push_back(b);
            wr(16'h8000, {8'h00, b});
        end
        while (cyc < n + 42) tick();
        sb.push_back(8'hE7);
        wr(16'h8000, 16'h00E7);
        rd_chk("status_pushpop", 16'h8001, 16'h0045);
        wait_frames(f0 + 6, 500);

        repeat (3) tick();
        n = cyc;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            sb.push_back(b);
            wr(16'h8000, {8'h00, b});
        end
        while (cyc < n + 10) tick();
        f0 = frames;
        rst = 1'b1;
        write_enable = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_tx", {31'h0, uart_tx}, 32'd1);
        rst = 1'b0;
        sb.delete();
        rd_chk("rst_mid_status", 16'h8001, 16'h0002);
        lows = 0;
        repeat (100) begin
            if (uart_tx !== 1'b1) lows++;
            tick();
        end
        chk("tx_idle_after_rst", lows, 32'd0);
        chk("no_frames_after_rst", frames, f0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
